// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit for the multicycle RV core.
//
// Owns the architectural PC. For each instruction it issues one read on a
// simplified AXI-lite read channel. It then presents {inst, inst_pc, inst_fault}
// to decode with a valid/ready handshake. After that it waits for the next PC
// commit before fetching again, so only one instruction is ever in flight.
//
// Ports:
//   clk, rst       core clock, synchronous active-high reset
//   next_pc/pc_wen PC commit from the PC-select logic (honoured in WAIT_PC only)
//   araddr/arvalid/arready        read address channel
//   rdata/rresp/rvalid/rready     read data channel (rresp != 0 -> access fault)
//   inst/inst_pc/inst_fault       instruction to decode (fault: 01 access, 10 misaligned)
//   inst_valid/inst_ready         decode handshake
//   curr_pc        architectural PC register
//   fetch_cnt      number of completed bus fetches (wraps)
//
// Every output comes straight from a flop. No input reaches an output
// combinationally.
module ifu_fetch #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0]          NOP_INST  = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CPU_WIDTH-1:0] next_pc,
    input  logic                 pc_wen,
    output logic [CPU_WIDTH-1:0] araddr,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [31:0]          rdata,
    input  logic [1:0]           rresp,
    input  logic                 rvalid,
    output logic                 rready,
    output logic [31:0]          inst,
    output logic [CPU_WIDTH-1:0] inst_pc,
    output logic [1:0]           inst_fault,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [CPU_WIDTH-1:0] curr_pc,
    output logic [31:0]          fetch_cnt
);

    typedef enum logic [1:0] {REQ, RESP, OUT, WAIT_PC} state_e;

    localparam logic [1:0] FAULT_NONE   = 2'b00;
    localparam logic [1:0] FAULT_ACCESS = 2'b01;
    localparam logic [1:0] FAULT_ALIGN  = 2'b10;

    state_e                 state_q, state_d;
    logic [CPU_WIDTH-1:0]   curr_pc_q, curr_pc_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q, rready_d;
    logic [31:0]            inst_q, inst_d;
    logic [CPU_WIDTH-1:0]   inst_pc_q, inst_pc_d;
    logic [1:0]             inst_fault_q, inst_fault_d;
    logic                   inst_valid_q, inst_valid_d;
    logic [31:0]            fetch_cnt_q, fetch_cnt_d;

    logic curr_misaligned;
    logic next_misaligned;

    assign curr_misaligned = (curr_pc_q[1:0] != 2'b00);
    assign next_misaligned = (next_pc[1:0] != 2'b00);

    // State register and all output flops.
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REQ;
            curr_pc_q    <= RESET_PC;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= RESET_PC;
            inst_fault_q <= FAULT_NONE;
            inst_valid_q <= 1'b0;
            fetch_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            curr_pc_q    <= curr_pc_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
            inst_valid_q <= inst_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    // Next-state logic. REQ with arvalid low only happens in the first cycle
    // after reset. That cycle decides between issuing the request and
    // reporting a misaligned reset PC.
    always_comb begin
        // NOTE: default first so no path through the case infers a latch.
        state_d = state_q;
        unique case (state_q)
            REQ: begin
                if (!arvalid_q && curr_misaligned) state_d = OUT;
                else if (arvalid_q && arready)     state_d = RESP;
            end
            RESP:    if (rvalid)     state_d = OUT;
            OUT:     if (inst_ready) state_d = WAIT_PC;
            WAIT_PC: if (pc_wen)     state_d = next_misaligned ? OUT : REQ;
        endcase
    end

    // Next values of the registered outputs. arvalid/rready are set on the
    // transition into REQ/RESP, so they are already high in the first cycle
    // of those states.
    always_comb begin
        curr_pc_d    = curr_pc_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;
        inst_valid_d = inst_valid_q;
        fetch_cnt_d  = fetch_cnt_q;
        unique case (state_q)
            REQ: begin
                if (!arvalid_q) begin
                    if (curr_misaligned) begin
                        inst_d       = NOP_INST;
                        inst_pc_d    = curr_pc_q;
                        inst_fault_d = FAULT_ALIGN;
                        inst_valid_d = 1'b1;
                    end else begin
                        arvalid_d = 1'b1;
                    end
                end else if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RESP: begin
                if (rvalid) begin
                    rready_d     = 1'b0;
                    inst_d       = (rresp != 2'b00) ? NOP_INST : rdata;
                    inst_pc_d    = curr_pc_q;
                    inst_fault_d = (rresp != 2'b00) ? FAULT_ACCESS : FAULT_NONE;
                    inst_valid_d = 1'b1;
                    fetch_cnt_d  = fetch_cnt_q + 32'd1;
                end
            end
            OUT: begin
                if (inst_ready) inst_valid_d = 1'b0;
            end
            WAIT_PC: begin
                if (pc_wen) begin
                    curr_pc_d = next_pc;
                    if (next_misaligned) begin
                        inst_d       = NOP_INST;
                        inst_pc_d    = next_pc;
                        inst_fault_d = FAULT_ALIGN;
                        inst_valid_d = 1'b1;
                    end else begin
                        arvalid_d = 1'b1;
                    end
                end
            end
        endcase
    end

    assign araddr     = curr_pc_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = inst_fault_q;
    assign inst_valid = inst_valid_q;
    assign curr_pc    = curr_pc_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule
